accum_op_sequencer: RTL and testbench
=====================================

// Module: accum_op_sequencer
// PURPOSE
//  Instruction sequencer for the adder/accumulator datapath (A reg, B reg, ALU, shared 8-bit bus).
//  Accepts one opcode at a time over a valid/ready handshake and steps the datapath through it.
//  Emits the per-cycle control word: A/B load strobes (active-low), A/ALU bus enables, sub select,
//  external-data bus enable and output-latch strobe.
//  Sits between the top-level pin decode and the alu / accumulator_register instances.
// PARAMETERS
//  CNT_W  8  width of retired-instruction counter (wraps modulo 2**CNT_W)
// PORTS
//  clk          in   1      clock; all state changes on rising edge
//  rst          in   1      synchronous, active-high reset
//  op_valid     in   1      opcode on op_code is valid
//  op_code      in   3      0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 OUT, 5/6 reserved, 7 HLT
//  op_ready     out  1      sequencer can accept an opcode (IDLE only)
//  ctl_ei       out  1      drive external data (ui_in) onto bus
//  ctl_nla      out  1      load A from bus, active-low
//  ctl_nlb      out  1      load B from bus, active-low
//  ctl_ea       out  1      A drives bus
//  ctl_eu       out  1      ALU result drives bus
//  ctl_sub      out  1      ALU subtract select
//  ctl_nlo      out  1      load output latch from bus, active-low
//  done         out  1      one-cycle pulse on last execute cycle of each opcode
//  halted       out  1      HLT executed; sticky until rst
//  illegal      out  1      sticky: reserved opcode accepted
//  retired      out  CNT_W  count of completed opcodes, HLT included
// BEHAVIOUR
//  States: IDLE, EX1, EX2, HALT. Opcode latched into op_q on accept.
//  Accept: op_valid & op_ready in IDLE. Next state is EX1 for all opcodes except HLT.
//   HLT goes directly to HALT, pulses done and increments retired in that cycle.
//  Control outputs are Moore: decoded from state/op_q only, never from inputs.
//  Defaults in every state not listed: nla=nlb=nlo=1; ei=ea=eu=sub=0.
//  EX1 per opcode:
//   LDA: ei=1, nla=0 -> IDLE
//   ADD/SUB: ei=1, nlb=0 -> EX2
//   OUT: ea=1, nlo=0 -> IDLE
//   NOP/reserved: no strobes -> IDLE; reserved also sets illegal.
//  EX2 (ADD/SUB only): eu=1, nla=0, sub=(op_q==SUB) -> IDLE.
//   A captures A±B at the end of EX2. The ALU updates its CF/ZF itself on eu.
//  Latency from accept to done pulse:
//   1 cycle: LDA/OUT/NOP/reserved
//   2 cycles: ADD/SUB
//   0 cycles: HLT (done in the accept cycle)
//  done=1 in the final execute cycle. retired increments at that edge and wraps silently.
//  Throughput: op_ready=1 only in IDLE, so one opcode every 2 cycles (3 for ADD/SUB).
//  Bus invariant: at most one of {ei, ea, eu} is high in any cycle.
//  HALT: op_ready=0 and all controls at defaults. Only rst leaves it.
//  op_valid while not ready is ignored; the producer must hold it. No internal queue.
//  Reset (any state, mid-op included) -> IDLE, op_ready=1, controls at defaults,
//   done=0, halted=0, illegal=0, retired=0. An in-flight opcode is abandoned and A is not written.
// STRUCTURE
//  Shared package: opcode localparams (OP_NOP..OP_HLT), state encoding, and
//   a control-word struct/bit-index constants {ei,nla,nlb,ea,eu,sub,nlo} with DEFAULT_CTL.
//  One sub-module is natural: accum_ctl_decode, a pure combinational map (state, op_q) -> control word.
//  The FSM, handshake and counters stay in this module.
// TESTING
//  rst, then LDA with bus=0x05 -> EX1: ei=1, nla=0. done at +1 cycle; A=0x05; retired=1.
//  LDA 0x05, then ADD 0x03 -> EX1: nlb=0. EX2: eu=1, nla=0, sub=0; A=0x08; done only in EX2.
//  A=0x03, SUB 0x03 -> EX2 sub=1; A=0x00, ZF=1. Then OUT -> ea=1, nlo=0, output latch=0x00.
//  op_valid held through ADD -> op_ready=0 in EX1/EX2. Next accept occurs in the IDLE cycle after EX2.
//  Opcode 6 -> illegal=1, no strobes, done pulse. HLT -> halted=1, op_ready=0 forever until rst.
//  rst asserted in EX1 of ADD -> next cycle IDLE, all defaults, A unchanged.
//   Also assert every cycle: at most one of {ei, ea, eu} high.

Source files
------------

// File: rtl/accum_op_sequencer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | accum_op_sequencer_pkg : opcodes, FSM states, control-word type |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package accum_op_sequencer_pkg;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LDA = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_OUT = 3'd4;
    localparam logic [2:0] OP_RS5 = 3'd5;
    localparam logic [2:0] OP_RS6 = 3'd6;
    localparam logic [2:0] OP_HLT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EX1  = 2'd1,
        ST_EX2  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    // Packed MSB-first, so bit indices below follow declaration order.
    typedef struct packed {
        logic ei;
        logic nla;
        logic nlb;
        logic ea;
        logic eu;
        logic sub;
        logic nlo;
    } ctl_t;

    localparam int CTL_EI  = 6;
    localparam int CTL_NLA = 5;
    localparam int CTL_NLB = 4;
    localparam int CTL_EA  = 3;
    localparam int CTL_EU  = 2;
    localparam int CTL_SUB = 1;
    localparam int CTL_NLO = 0;

    localparam ctl_t DEFAULT_CTL = '{ei: 1'b0, nla: 1'b1, nlb: 1'b1, ea: 1'b0,
                                     eu: 1'b0, sub: 1'b0, nlo: 1'b1};

    function automatic logic op_is_reserved(input logic [2:0] op);
        return (op == OP_RS5) || (op == OP_RS6);
    endfunction

    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/accum_op_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | accum_op_sequencer_if : opcode handshake, control word, status  |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
interface accum_op_sequencer_if #(
    parameter int CNT_W = 8
) ();
    logic             op_valid;
    logic [2:0]       op_code;
    logic             op_ready;
    logic             ctl_ei;
    logic             ctl_nla;
    logic             ctl_nlb;
    logic             ctl_ea;
    logic             ctl_eu;
    logic             ctl_sub;
    logic             ctl_nlo;
    logic             done;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        output op_valid, op_code,
        input  op_ready, ctl_ei, ctl_nla, ctl_nlb, ctl_ea, ctl_eu, ctl_sub, ctl_nlo,
        input  done, halted, illegal, retired
    );

    modport slave (
        input  op_valid, op_code,
        output op_ready, ctl_ei, ctl_nla, ctl_nlb, ctl_ea, ctl_eu, ctl_sub, ctl_nlo,
        output done, halted, illegal, retired
    );
endinterface
`default_nettype wire

// File: rtl/accum_op_sequencer_ctl_decode.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | accum_op_sequencer_ctl_decode : (state, op_q) -> control word   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module accum_op_sequencer_ctl_decode
    import accum_op_sequencer_pkg::*;
(
    input  state_e     i_state,
    input  logic [2:0] i_op,
    output ctl_t       o_ctl,
    output logic       o_last
);

    always_comb begin
        o_ctl  = DEFAULT_CTL;
        o_last = 1'b0;
        case (i_state)
            ST_EX1: begin
                o_last = 1'b1;
                case (i_op)
                    OP_LDA: begin
                        o_ctl.ei  = 1'b1;
                        o_ctl.nla = 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        // B captures the operand now; A is written in EX2
                        o_ctl.ei  = 1'b1;
                        o_ctl.nlb = 1'b0;
                        o_last    = 1'b0;
                    end
                    OP_OUT: begin
                        o_ctl.ea  = 1'b1;
                        o_ctl.nlo = 1'b0;
                    end
                    OP_NOP: ;
                    default: ;
                endcase
            end
            ST_EX2: begin
                o_ctl.eu  = 1'b1;
                o_ctl.nla = 1'b0;
                o_ctl.sub = (i_op == OP_SUB);
                o_last    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/accum_op_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | accum_op_sequencer : opcode FSM driving the A/B/ALU datapath    |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module accum_op_sequencer
    import accum_op_sequencer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  wire              clk,
    input  wire              rst,
    accum_op_sequencer_if.slave bus
);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    ctl_t w_ctl;
    logic w_exec_last;
    logic w_accept;
    logic w_hlt_accept;
    logic w_done;

    accum_op_sequencer_ctl_decode u_ctl_decode (
        .i_state (state_q),
        .i_op    (op_q),
        .o_ctl   (w_ctl),
        .o_last  (w_exec_last)
    );

    assign w_accept     = bus.op_valid && (state_q == ST_IDLE);
    // HLT retires in its accept cycle, so done is not purely Moore here
    assign w_hlt_accept = w_accept && (bus.op_code == OP_HLT);
    assign w_done       = w_exec_last || w_hlt_accept;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    op_d = bus.op_code;
                    if (w_hlt_accept) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = ST_EX1;
                    end
                end
            end
            ST_EX1: begin
                state_d = op_is_arith(op_q) ? ST_EX2 : ST_IDLE;
                if (op_is_reserved(op_q)) begin
                    illegal_d = 1'b1;
                end
            end
            ST_EX2:  state_d = ST_IDLE;
            default: state_d = ST_HALT;
        endcase
        if (w_done) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NOP;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign bus.op_ready = (state_q == ST_IDLE);
    assign bus.ctl_ei   = w_ctl[CTL_EI];
    assign bus.ctl_nla  = w_ctl[CTL_NLA];
    assign bus.ctl_nlb  = w_ctl[CTL_NLB];
    assign bus.ctl_ea   = w_ctl[CTL_EA];
    assign bus.ctl_eu   = w_ctl[CTL_EU];
    assign bus.ctl_sub  = w_ctl[CTL_SUB];
    assign bus.ctl_nlo  = w_ctl[CTL_NLO];
    assign bus.done     = w_done;
    assign bus.halted   = halted_q;
    assign bus.illegal  = illegal_q;
    assign bus.retired  = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_accum_op_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_accum_op_sequencer : random opcode stream vs arithmetic model |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_accum_op_sequencer;

    localparam int         CNT_W = 8;
    localparam logic [6:0] DEF   = 7'b0110001;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [7:0] ui_in = 8'h00;

    int checks   = 0;
    int failures = 0;

    accum_op_sequencer_if #(.CNT_W(CNT_W)) bus ();

    accum_op_sequencer #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Datapath environment: A, B, output latch and ZF reacting to the control word
    logic [7:0] a_r   = 8'h00;
    logic [7:0] b_r   = 8'h00;
    logic [7:0] out_r = 8'h00;
    logic       zf_r  = 1'b0;
    logic [7:0] bus_v;
    logic [6:0] ctl_w;

    assign ctl_w = {bus.ctl_ei, bus.ctl_nla, bus.ctl_nlb, bus.ctl_ea,
                    bus.ctl_eu, bus.ctl_sub, bus.ctl_nlo};

    always_comb begin
        bus_v = 8'h00;
        if (bus.ctl_ei)      bus_v = ui_in;
        else if (bus.ctl_ea) bus_v = a_r;
        else if (bus.ctl_eu) bus_v = bus.ctl_sub ? (a_r - b_r) : (a_r + b_r);
    end

    always @(posedge clk) begin
        if (!bus.ctl_nla) a_r   <= bus_v;
        if (!bus.ctl_nlb) b_r   <= bus_v;
        if (!bus.ctl_nlo) out_r <= bus_v;
        if (bus.ctl_eu)   zf_r  <= (bus_v == 8'h00);
    end

    always @(negedge clk) begin
        if (!rst) check("bus_exclusive", ($countones({bus.ctl_ei, bus.ctl_ea, bus.ctl_eu}) <= 1), 1);
    end

    // Reference model state
    logic [7:0]       a_m       = 8'h00;
    logic [7:0]       out_m     = 8'h00;
    logic             zf_m      = 1'b0;
    logic             illegal_m = 1'b0;
    logic [CNT_W-1:0] count_m   = '0;

    function automatic logic [6:0] exp_ctl(input logic [2:0] op, input int cyc);
        case (op)
            3'd1:       return 7'b1010001;
            3'd2:       return (cyc == 1) ? 7'b1100001 : 7'b0010101;
            3'd3:       return (cyc == 1) ? 7'b1100001 : 7'b0010111;
            3'd4:       return 7'b0111000;
            default:    return DEF;
        endcase
    endfunction

    task automatic post_checks(input string tag);
        check({tag, "_a"},       a_r, a_m);
        check({tag, "_out"},     out_r, out_m);
        check({tag, "_zf"},      zf_r, zf_m);
        check({tag, "_retired"}, bus.retired, count_m);
        check({tag, "_illegal"}, bus.illegal, illegal_m);
        check({tag, "_halted"},  bus.halted, 0);
        check({tag, "_ready"},   bus.op_ready, 1);
        check({tag, "_ctl"},     ctl_w, DEF);
    endtask

    // Called at negedge+1 in IDLE; returns at negedge+1 in the following IDLE
    task automatic run_op(input logic [2:0] op, input logic [7:0] data);
        int n;
        n = (op == 3'd2 || op == 3'd3) ? 2 : 1;
        bus.op_valid = 1'b1;
        bus.op_code  = op;
        ui_in        = data;
        #1;
        check("done_at_accept", bus.done, 0);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("ctl_op%0d_cyc%0d", op, c), ctl_w, exp_ctl(op, c));
            check("ready_busy", bus.op_ready, 0);
            check($sformatf("done_op%0d_cyc%0d", op, c), bus.done, (c == n));
            if (c == n) bus.op_valid = 1'b0;
        end
        case (op)
            3'd1: a_m = data;
            3'd2: begin a_m = a_m + data; zf_m = (a_m == 8'h00); end
            3'd3: begin a_m = a_m - data; zf_m = (a_m == 8'h00); end
            3'd4: out_m = a_m;
            3'd5, 3'd6: illegal_m = 1'b1;
            default: ;
        endcase
        count_m = count_m + 1'b1;
        @(negedge clk);
        #1;
        post_checks($sformatf("after_op%0d", op));
    endtask

    task automatic idle_cycle();
        bus.op_valid = 1'b0;
        @(negedge clk);
        #1;
        check("idle_done", bus.done, 0);
        check("idle_ready", bus.op_ready, 1);
    endtask

    initial begin
        logic [2:0] rop;
        bus.op_valid = 1'b0;
        bus.op_code  = 3'd0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_ready", bus.op_ready, 1);
        check("reset_ctl", ctl_w, DEF);
        check("reset_done", bus.done, 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        post_checks("reset");

        // Directed sequence
        run_op(3'd1, 8'h05);
        run_op(3'd2, 8'h03);
        run_op(3'd1, 8'h03);
        run_op(3'd3, 8'h03);
        check("sub_zero_zf", zf_r, 1);
        run_op(3'd4, 8'hA5);
        check("out_latch_zero", out_r, 8'h00);
        run_op(3'd6, 8'h11);
        check("illegal_set", bus.illegal, 1);

        // Random stream, opcodes 0..6
        for (int i = 0; i < 80; i++) begin
            rop = 3'($urandom_range(0, 6));
            run_op(rop, 8'($urandom));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        // Retired counter wrap
        for (int i = 0; i < 260; i++) run_op(3'd0, 8'($urandom));

        // Reset in EX1 of ADD: A must not be written
        run_op(3'd1, 8'($urandom));
        bus.op_valid = 1'b1;
        bus.op_code  = 3'd2;
        ui_in        = 8'h77;
        @(negedge clk);
        #1;
        check("mid_ex1_ctl", ctl_w, 7'b1100001);
        rst          = 1'b1;
        bus.op_valid = 1'b0;
        @(negedge clk);
        #1;
        rst       = 1'b0;
        count_m   = '0;
        illegal_m = 1'b0;
        check("midrst_done", bus.done, 0);
        post_checks("midrst");
        run_op(3'd2, 8'h10);

        // HLT: done in the accept cycle, then stuck until reset
        bus.op_valid = 1'b1;
        bus.op_code  = 3'd7;
        #1;
        check("hlt_done_accept", bus.done, 1);
        count_m = count_m + 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.op_code = 3'($urandom_range(0, 7));
            #1;
            check("halt_halted", bus.halted, 1);
            check("halt_ready", bus.op_ready, 0);
            check("halt_ctl", ctl_w, DEF);
            check("halt_done", bus.done, 0);
            check("halt_retired", bus.retired, count_m);
        end
        rst          = 1'b1;
        bus.op_valid = 1'b0;
        @(negedge clk);
        #1;
        rst     = 1'b0;
        count_m = '0;
        post_checks("after_halt_rst");
        run_op(3'd1, 8'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
